frame_update_scheduler: RTL and testbench

- Consumer end of the 60 Hz frame tick.
- Takes the single-cycle `tick_in` pulse from the 60 Hz tick generator and queues update requests.
- Issues each request to the game-logic block over a 4-phase req/ack handshake, and counts completed frames.
- Flags overruns when game logic falls too far behind the tick rate. Sits between the tick generator and the game/render update FSMs.

---
 rtl/frame_sched_pkg.sv | 18 +
 rtl/rising_edge_detect.sv | 20 ++
 rtl/frame_update_scheduler.sv | 114 +++++++++++
 tb/tb_frame_update_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and helpers for the frame update scheduler.
// Holds the handshake FSM state encoding and the queue width helper.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RELEASE = 2'd2
    } sched_state_t;

    localparam int DEF_MAX_PENDING = 3;

    // Bits needed to hold a pending count of 0..max_pend.
    function automatic int pend_width(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Single-cycle pulse on each low-to-high transition of a level.
// Ports: clock_in, resetn (async, active-low), level_in -> pulse_out.
module rising_edge_detect (
    input  logic clock_in,
    input  logic resetn,
    input  logic level_in,
    output logic pulse_out
);

    logic r_level_q;

    // Reset value 0 lets a level already high after reset count once.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) r_level_q <= 1'b0;
        else         r_level_q <= level_in;
    end

    assign pulse_out = level_in & ~r_level_q;

endmodule

// File: rtl/frame_update_scheduler.sv
// Queues 60 Hz frame ticks and issues them to game logic over a 4-phase
// req/ack handshake, counting completed frames and flagging dropped ticks.
// Ports: clock_in, resetn, tick_in, enable, update_ack, overrun_clear (in);
//        update_req, frame_count, pending, busy, overrun (registered out).
module frame_update_scheduler
    import frame_sched_pkg::*;
#(
    parameter int MAX_PENDING       = DEF_MAX_PENDING,
    parameter int FRAME_COUNT_WIDTH = 16
) (
    input  logic                                clock_in,
    input  logic                                resetn,
    input  logic                                tick_in,
    input  logic                                enable,
    output logic                                update_req,
    input  logic                                update_ack,
    output logic [FRAME_COUNT_WIDTH-1:0]        frame_count,
    output logic [pend_width(MAX_PENDING)-1:0]  pending,
    output logic                                busy,
    output logic                                overrun,
    input  logic                                overrun_clear
);

    localparam int PW = pend_width(MAX_PENDING);
    localparam logic [PW-1:0] MAXP = PW'(MAX_PENDING);

    sched_state_t                 r_state;
    sched_state_t                 w_next;
    logic                         r_req;
    logic                         r_busy;
    logic                         r_overrun;
    logic [PW-1:0]                r_pend;
    logic [PW-1:0]                w_pend_nxt;
    logic [FRAME_COUNT_WIDTH-1:0] r_count;
    logic                         w_tick;
    logic                         w_deq;
    logic                         w_done;
    logic                         w_accept;
    logic                         w_drop;

    rising_edge_detect u_tick_edge (
        .clock_in  (clock_in),
        .resetn    (resetn),
        .level_in  (tick_in),
        .pulse_out (w_tick)
    );

    // A full queue still accepts a tick in the cycle a slot is dequeued.
    assign w_accept = w_tick & enable & ((r_pend != MAXP) | w_deq);
    assign w_drop   = w_tick & enable & (r_pend == MAXP) & ~w_deq;

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_accept && !w_deq)
            w_pend_nxt = r_pend + PW'(1);
        else if (!w_accept && w_deq)
            w_pend_nxt = r_pend - PW'(1);
    end

    always_comb begin
        w_next = r_state;
        w_deq  = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pend != '0) begin
                    w_next = REQUEST;
                    w_deq  = 1'b1;
                end
            end
            REQUEST: begin
                // Ack only counts while our request is actually raised.
                if (update_ack && r_req) begin
                    w_next = RELEASE;
                    w_done = 1'b1;
                end
            end
            RELEASE: begin
                if (!update_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_pend    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == REQUEST);
            r_busy  <= (w_next != IDLE);
            r_pend  <= w_pend_nxt;
            if (w_done)
                r_count <= r_count + FRAME_COUNT_WIDTH'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)
                r_overrun <= 1'b1;
            else if (overrun_clear)
                r_overrun <= 1'b0;
        end
    end

    assign update_req  = r_req;
    assign busy        = r_busy;
    assign pending     = r_pend;
    assign frame_count = r_count;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed self-checking bench for frame_update_scheduler.
// Uses MAX_PENDING=3 and a 4-bit frame counter so wrap is reachable.
module tb_frame_update_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick_in = 1'b0;
    logic       enable = 1'b0;
    logic       update_ack = 1'b0;
    logic       overrun_clear = 1'b0;
    logic       update_req;
    logic [3:0] frame_count;
    logic [1:0] pending;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frame_update_scheduler #(
        .MAX_PENDING       (3),
        .FRAME_COUNT_WIDTH (4)
    ) dut (
        .clock_in      (clk),
        .resetn        (resetn),
        .tick_in       (tick_in),
        .enable        (enable),
        .update_req    (update_req),
        .update_ack    (update_ack),
        .frame_count   (frame_count),
        .pending       (pending),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clear (overrun_clear)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick_in = 1'b0;
        enable = 1'b1;
        update_ack = 1'b0;
        overrun_clear = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    // One tick: high for one edge, low for one edge.
    task automatic tick1();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
    endtask

    initial begin
        // Reset and first-request latency
        do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_req", {31'd0, update_req}, 0);
        chk("rst_cnt", {28'd0, frame_count}, 0);
        chk("rst_pend", {30'd0, pending}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ovr", {31'd0, overrun}, 0);
        step();
        resetn = 1'b1;
        tick_in = 1'b1;
        step();
        chk("lat_pend_t", {30'd0, pending}, 1);
        chk("lat_req_t", {31'd0, update_req}, 0);
        tick_in = 1'b0;
        step();
        chk("lat_req_t1", {31'd0, update_req}, 1);
        chk("lat_pend_t1", {30'd0, pending}, 0);
        chk("lat_busy_t1", {31'd0, busy}, 1);
        step();
        step();
        chk("req_held", {31'd0, update_req}, 1);
        update_ack = 1'b1;
        step();
        chk("ack_req", {31'd0, update_req}, 0);
        chk("ack_cnt", {28'd0, frame_count}, 1);
        chk("rel_busy", {31'd0, busy}, 1);
        update_ack = 1'b0;
        step();
        chk("idle_busy", {31'd0, busy}, 0);

        // Held tick counts once
        do_reset();
        tick_in = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("held_pend", {30'd0, pending}, 0);
        chk("held_req", {31'd0, update_req}, 1);
        tick_in = 1'b0;
        update_ack = 1'b1;
        step();
        update_ack = 1'b0;
        step();
        step();
        step();
        chk("held_cnt", {28'd0, frame_count}, 1);
        chk("held_req2", {31'd0, update_req}, 0);
        chk("held_busy", {31'd0, busy}, 0);

        // Overrun with ack held low, then clear-vs-set
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            step();
            step();
            step();
        end
        chk("ovr_pend", {30'd0, pending}, 3);
        chk("ovr_flag", {31'd0, overrun}, 1);
        chk("ovr_req", {31'd0, update_req}, 1);
        tick_in = 1'b1;
        overrun_clear = 1'b1;
        step();
        chk("clr_vs_set", {31'd0, overrun}, 1);
        chk("clr_vs_pend", {30'd0, pending}, 3);
        tick_in = 1'b0;
        step();
        chk("clr_alone", {31'd0, overrun}, 0);
        overrun_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            update_ack = 1'b1;
            step();
            update_ack = 1'b0;
            step();
            step();
            if (i == 0) chk("drain_pend1", {30'd0, pending}, 2);
        end
        chk("drain_cnt", {28'd0, frame_count}, 4);
        chk("drain_pend", {30'd0, pending}, 0);
        chk("drain_req", {31'd0, update_req}, 0);

        // Enable gating
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick1();
        chk("en0_pend", {30'd0, pending}, 0);
        chk("en0_req", {31'd0, update_req}, 0);
        chk("en0_ovr", {31'd0, overrun}, 0);
        enable = 1'b1;
        tick1();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        enable = 1'b0;
        step();
        tick1();
        chk("en_q_pend", {30'd0, pending}, 1);
        chk("en_q_req", {31'd0, update_req}, 1);
        update_ack = 1'b1;
        step();
        chk("en_cnt1", {28'd0, frame_count}, 1);
        update_ack = 1'b0;
        step();
        step();
        chk("en_drain_req", {31'd0, update_req}, 1);
        chk("en_drain_pend", {30'd0, pending}, 0);
        update_ack = 1'b1;
        step();
        update_ack = 1'b0;
        step();
        step();
        chk("en_cnt2", {28'd0, frame_count}, 2);
        chk("en_busy", {31'd0, busy}, 0);

        // Stuck ack blocks the next request
        do_reset();
        tick1();
        tick1();
        tick1();
        chk("stk_pend", {30'd0, pending}, 2);
        update_ack = 1'b1;
        step();
        step();
        step();
        step();
        chk("stk_req", {31'd0, update_req}, 0);
        chk("stk_busy", {31'd0, busy}, 1);
        chk("stk_pend2", {30'd0, pending}, 2);
        update_ack = 1'b0;
        step();
        chk("stk_rel_req", {31'd0, update_req}, 0);
        chk("stk_rel_busy", {31'd0, busy}, 0);
        step();
        chk("stk_rereq", {31'd0, update_req}, 1);
        chk("stk_rereq_pend", {30'd0, pending}, 1);

        // Async reset while in REQUEST
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_req", {31'd0, update_req}, 0);
        chk("arst_pend", {30'd0, pending}, 0);
        chk("arst_cnt", {28'd0, frame_count}, 0);
        chk("arst_busy", {31'd0, busy}, 0);

        // Counter wrap at 4 bits
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            tick1();
            update_ack = 1'b1;
            step();
            update_ack = 1'b0;
            step();
            if (i == 15) chk("wrap_15", {28'd0, frame_count}, 15);
            if (i == 16) chk("wrap_16", {28'd0, frame_count}, 0);
        end
        chk("wrap_17", {28'd0, frame_count}, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
